mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 213 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store unit between a RISC-V style CPU request port and a single-port word RAM.
// Sub-word stores use a read-modify-write sequence; misaligned or illegal requests complete with an error.
module mem_access_unit #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_address,
    output logic [31:0]       ram_write_data,
    input  logic [31:0]       ram_read_data
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RMW_RD = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                we_r;
    logic [2:0]          funct3_r;
    logic [ADDR_W+1:0]   addr_r;
    logic [31:0]         wdata_r;
    logic [31:0]         word_r;
    logic [31:0]         resp_rdata_r;
    logic                resp_err_r;
    logic                resp_valid_r;
    logic                accept_s;
    logic                bad_s;
    logic                unused_addr_s;

    // Illegal width code or an address not aligned to the access size.
    function automatic logic req_bad(input logic we, input logic [2:0] f3, input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        if (we) begin
            case (f3)
                3'd0:    bad = 1'b0;
                3'd1:    bad = a[0];
                3'd2:    bad = (a != 2'd0);
                default: bad = 1'b1;
            endcase
        end else begin
            case (f3)
                3'd0, 3'd4: bad = 1'b0;
                3'd1, 3'd5: bad = a[0];
                3'd2:       bad = (a != 2'd0);
                default:    bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (a)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'd0;
        endcase
        h = a[1] ? word[31:16] : word[15:0];
        case (f3)
            3'd0:    res = {{24{b[7]}}, b};
            3'd1:    res = {{16{h[15]}}, h};
            3'd2:    res = word;
            3'd4:    res = {24'd0, b};
            3'd5:    res = {16'd0, h};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] word, input logic [31:0] wd);
        logic [31:0] res;
        res = word;
        case (f3)
            3'd0: begin
                case (a)
                    2'd0:    res[7:0]   = wd[7:0];
                    2'd1:    res[15:8]  = wd[7:0];
                    2'd2:    res[23:16] = wd[7:0];
                    2'd3:    res[31:24] = wd[7:0];
                    default: res = word;
                endcase
            end
            3'd1: begin
                if (a[1]) begin
                    res[31:16] = wd[15:0];
                end else begin
                    res[15:0] = wd[15:0];
                end
            end
            default: res = wd;
        endcase
        return res;
    endfunction

    assign accept_s      = req_valid && (state_r == IDLE);
    assign bad_s         = req_bad(req_we, req_funct3, req_addr[1:0]);
    // Bits above the RAM window are intentionally dropped, so addresses wrap.
    assign unused_addr_s = ^req_addr[31:ADDR_W+2];

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    if (bad_s) begin
                        state_nxt_s = RESP;
                    end else if (!req_we) begin
                        state_nxt_s = LOAD;
                    end else if (req_funct3 == 3'd2) begin
                        state_nxt_s = WRITE;
                    end else begin
                        state_nxt_s = RMW_RD;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD:    state_nxt_s = RESP;
            RMW_RD:  state_nxt_s = WRITE;
            WRITE:   state_nxt_s = RESP;
            RESP:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Request latch, RMW capture and registered response.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            we_r         <= 1'b0;
            funct3_r     <= 3'd0;
            addr_r       <= '0;
            wdata_r      <= 32'd0;
            word_r       <= 32'd0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
            resp_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                we_r     <= req_we;
                funct3_r <= req_funct3;
                addr_r   <= req_addr[ADDR_W+1:0];
                wdata_r  <= req_wdata;
            end
            if (state_r == RMW_RD) begin
                word_r <= ram_read_data;
            end
            resp_valid_r <= (state_nxt_s == RESP);
            if (accept_s && bad_s) begin
                resp_err_r   <= 1'b1;
                resp_rdata_r <= 32'd0;
            end else if (state_r == LOAD) begin
                resp_err_r   <= 1'b0;
                resp_rdata_r <= load_extract(funct3_r, addr_r[1:0], ram_read_data);
            end else if (state_r == WRITE) begin
                resp_err_r   <= 1'b0;
                resp_rdata_r <= 32'd0;
            end else begin
                resp_err_r   <= resp_err_r;
                resp_rdata_r <= resp_rdata_r;
            end
        end
    end

    // RAM and handshake outputs; ram_we is gated by rstn so a reset drops an in-flight store.
    always_comb begin
        req_ready      = (state_r == IDLE);
        ram_we         = (state_r == WRITE) && rstn && we_r;
        ram_address    = addr_r[ADDR_W+1:2];
        ram_write_data = 32'd0;
        if (funct3_r == 3'd2) begin
            ram_write_data = wdata_r;
        end else begin
            ram_write_data = store_merge(funct3_r, addr_r[1:0], word_r, wdata_r);
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: behavioural RAM, scoreboard of expected responses.
module tb_mem_access_unit;

    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              rstn;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_address;
    logic [31:0]       ram_write_data;
    logic [31:0]       ram_read_data;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];
    logic              pl_en;
    logic [ADDR_W-1:0] pl_addr;
    logic [31:0]       pl_data;
    int                we_cnt;
    int                n_cmp;
    int                n_bad;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        logic [3:0]  lat;
    } exp_t;

    exp_t sb_q[$];

    mem_access_unit #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .ram_we         (ram_we),
        .ram_address    (ram_address),
        .ram_write_data (ram_write_data),
        .ram_read_data  (ram_read_data)
    );

    always #5 clk = ~clk;

    assign ram_read_data = mem[ram_address];

    // Behavioural RAM with a preload port for the bench.
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_address] <= ram_write_data;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end
    end

    // Count write strobes to prove exactly one write per store.
    always @(posedge clk) begin
        if (ram_we) begin
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(posedge clk);
        #1;
        pl_en = 1'b0;
    endtask

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat);
        exp_t e;
        int   n;
        int   lat;
        int   we0;
        e.err   = exp_err;
        e.rdata = exp_rdata;
        e.lat   = 4'(exp_lat);
        sb_q.push_back(e);
        we0 = we_cnt;
        @(negedge clk);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1;
        // Scramble the request bus after acceptance; the unit must use its latched copy.
        req_valid  = 1'b0;
        req_we     = ~we;
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = $urandom;
        req_wdata  = $urandom;
        lat = 1;
        while (!resp_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq({tag, "_err"}, 32'(resp_err), 32'(e.err));
            check_eq({tag, "_rdata"}, resp_rdata, e.rdata);
            check_eq({tag, "_latency"}, 32'(lat), 32'(e.lat));
        end
        @(posedge clk);
        #1;
        check_eq({tag, "_pulse_end"}, 32'(resp_valid), 32'd0);
        check_eq({tag, "_ready_again"}, 32'(req_ready), 32'd1);
        check_eq({tag, "_we_pulses"}, 32'(we_cnt - we0), (we && !exp_err) ? 32'd1 : 32'd0);
    endtask

    initial begin
        int we0;
        n_cmp      = 0;
        n_bad      = 0;
        we_cnt     = 0;
        pl_en      = 1'b0;
        pl_addr    = '0;
        pl_data    = 32'd0;
        rstn       = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", 32'(req_ready), 32'd1);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_ram_we", 32'(ram_we), 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'd0);
        check_eq("rst_err", 32'(resp_err), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rel_ready", 32'(req_ready), 32'd1);

        // Byte store through read-modify-write.
        preload(11'd5, 32'h1122_3344);
        do_req("sb", 1'b1, 3'd0, 32'h16, 32'h0000_00AB, 1'b0, 32'd0, 3);
        check_eq("sb_ram", mem[5], 32'h11AB_3344);

        // Loads with sign/zero extension.
        preload(11'd5, 32'h80FF_7F01);
        do_req("lb",   1'b0, 3'd0, 32'h17, 32'd0, 1'b0, 32'hFFFF_FF80, 2);
        do_req("lbu",  1'b0, 3'd4, 32'h17, 32'd0, 1'b0, 32'h0000_0080, 2);
        do_req("lh",   1'b0, 3'd1, 32'h14, 32'd0, 1'b0, 32'h0000_7F01, 2);
        do_req("lw",   1'b0, 3'd2, 32'h14, 32'd0, 1'b0, 32'h80FF_7F01, 2);
        do_req("lh_hi",  1'b0, 3'd1, 32'h16, 32'd0, 1'b0, 32'hFFFF_80FF, 2);
        do_req("lhu_hi", 1'b0, 3'd5, 32'h16, 32'd0, 1'b0, 32'h0000_80FF, 2);
        do_req("lb_b0",  1'b0, 3'd0, 32'h14, 32'd0, 1'b0, 32'h0000_0001, 2);

        // Misaligned and illegal requests.
        preload(11'd8, 32'hDEAD_BEEF);
        do_req("sw_mis", 1'b1, 3'd2, 32'h22, 32'h1234_5678, 1'b1, 32'd0, 1);
        check_eq("sw_mis_ram", mem[8], 32'hDEAD_BEEF);
        do_req("sh_mis", 1'b1, 3'd1, 32'h21, 32'h0000_5555, 1'b1, 32'd0, 1);
        do_req("lh_mis", 1'b0, 3'd1, 32'h15, 32'd0, 1'b1, 32'd0, 1);
        do_req("ld_f3",  1'b0, 3'd3, 32'h20, 32'd0, 1'b1, 32'd0, 1);
        do_req("st_f3",  1'b1, 3'd4, 32'h20, 32'h0000_00FF, 1'b1, 32'd0, 1);
        check_eq("ill_ram", mem[8], 32'hDEAD_BEEF);

        // Word and halfword stores.
        do_req("sw", 1'b1, 3'd2, 32'h20, 32'hCAFE_F00D, 1'b0, 32'd0, 2);
        check_eq("sw_ram", mem[8], 32'hCAFE_F00D);
        do_req("sh", 1'b1, 3'd1, 32'h22, 32'h0000_1234, 1'b0, 32'd0, 3);
        check_eq("sh_ram", mem[8], 32'h1234_F00D);
        do_req("sw_rb", 1'b0, 3'd2, 32'h20, 32'd0, 1'b0, 32'h1234_F00D, 2);

        // Address wrap beyond the RAM window.
        preload(11'd1, 32'h0102_0304);
        do_req("wrap", 1'b0, 3'd2, 32'h2004, 32'd0, 1'b0, 32'h0102_0304, 2);

        // Reset during the write cycle of a halfword store.
        preload(11'd8, 32'h5566_7788);
        we0 = we_cnt;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd1;
        req_addr   = 32'h20;
        req_wdata  = 32'h0000_BEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("mid_we_before", 32'(ram_we), 32'd1);
        rstn = 1'b0;
        #1;
        check_eq("mid_we_gated", 32'(ram_we), 32'd0);
        @(posedge clk);
        #1;
        check_eq("mid_ready", 32'(req_ready), 32'd1);
        check_eq("mid_resp_valid", 32'(resp_valid), 32'd0);
        rstn = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_eq("mid_no_resp", 32'(resp_valid), 32'd0);
        end
        check_eq("mid_ram", mem[8], 32'h5566_7788);
        check_eq("mid_we_cnt", 32'(we_cnt - we0), 32'd0);
        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
